// File: rtl/dpram_reader_pkg.sv
// Shared types and build constants for the capture-DPRAM frame reader.
// Define DPRAM_READER_OREG_EN when the RAM has its output register enabled (LAT=2).
package dpram_reader_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

`ifdef DPRAM_READER_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/dpram_reader_skid_fifo.sv
// Small synchronous FIFO that absorbs RAM read latency under stream backpressure.
// The valid flag is a register; data reads as zero whenever the FIFO is empty.
module dpram_reader_skid_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         valid_o,
    output logic [W-1:0]                 data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && valid_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign data_o  = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/dpram_frame_reader.sv
// Circular read engine for the capture DPRAM: issues addresses under FIFO credit
// and streams the returned samples with a last-beat marker. See DPRAM_READER_OREG_EN.
module dpram_frame_reader
    import dpram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

    if (FIFO_DEPTH < LAT + 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least LAT + 2");
    end

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, ram_addr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  busy_q, done_q;
    logic [LAT:0]          vld_pipe_q, tag_pipe_q;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_data;
    logic                  issue, last_acc;
    int                    inflight;

    // Credit counts every read not yet in the FIFO, including the one on ram_addr now.
    always_comb begin
        inflight = 0;
        for (int i = 0; i <= LAT; i++) inflight += int'(vld_pipe_q[i]);
        issue = (state_q == RUN) && (rem_q != '0) && !abort &&
                ((int'(fifo_count) + inflight) < FIFO_DEPTH);
    end

    assign last_acc = fifo_valid && m_ready && fifo_data[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            ram_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            done_q     <= 1'b0;
            vld_pipe_q <= {vld_pipe_q[LAT-1:0], issue};
            tag_pipe_q <= {tag_pipe_q[LAT-1:0], issue && (rem_q == (ADDR_WIDTH+1)'(1))};
            if (abort) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                rem_q      <= '0;
                vld_pipe_q <= '0;
                tag_pipe_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= start_addr;
                            rem_q   <= (length > DEPTH) ? DEPTH : length;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                    RUN: if (issue) begin
                        ram_addr_q <= addr_q;
                        addr_q     <= addr_q + 1'b1;
                        rem_q      <= rem_q - 1'b1;
                        if (rem_q == (ADDR_WIDTH+1)'(1)) state_q <= DRAIN;
                    end
                    DRAIN: if (last_acc) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    dpram_reader_skid_fifo #(
        .W     (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (abort),
        .push_i      (vld_pipe_q[LAT] && !abort),
        .push_data_i ({tag_pipe_q[LAT], ram_rd_data}),
        .pop_i       (m_valid && m_ready),
        .count_o     (fifo_count),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data)
    );

    assign ram_addr = ram_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign m_valid  = fifo_valid;
    assign m_data   = fifo_data[DATA_WIDTH-1:0];
    assign m_last   = fifo_data[DATA_WIDTH];

endmodule

// File: tb/tb_dpram_frame_reader.sv
// Directed bench for dpram_frame_reader: table of read requests plus abort,
// reset and ignored-start sequences, against a simple synchronous RAM model.
module tb_dpram_frame_reader;
    import dpram_reader_pkg::*;

    localparam int AW = 13;
    localparam int DW = 10;
    localparam int FD = 4;
    localparam int DEPTH = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rd_data, m_data;
    logic          m_valid, m_last, busy, done;
    logic [DW-1:0] rd_pipe [LAT];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   len;
        int            mode;
        int            exp_beats;
        bit            poke;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    dpram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .ram_addr(ram_addr),
        .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] ramf(input logic [AW-1:0] a);
        return a[DW-1:0] ^ {7'b0, a[AW-1:DW]};
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= ramf(ram_addr);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[LAT-1];

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 3) == 0;
            2:       return (cyc % 4) != 3;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, ":ram_addr"}, int'(ram_addr), 0);
        chk({tag, ":m_valid"}, int'(m_valid), 0);
        chk({tag, ":m_last"}, int'(m_last), 0);
        chk({tag, ":m_data"}, int'(m_data), 0);
        chk({tag, ":busy"}, int'(busy), 0);
        chk({tag, ":done"}, int'(done), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, beats, dones, first_v, last_cyc, done_cyc, naddr, exp_a;
        logic [AW-1:0] prev_ra;
        logic pv, pr, pl;
        logic [DW-1:0] pd;
        cyc = 0; beats = 0; dones = 0; first_v = -1; last_cyc = -1; done_cyc = -1;
        naddr = 0; prev_ra = '0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = v.addr; length = v.len;
        @(posedge clk); #1;
        start = 1'b0; start_addr = '0; length = '0;
        m_ready = rdy(v.mode, 0);
        while (cyc < 40000 && !(done_cyc >= 0 && cyc > done_cyc + 3)) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, ":busy_c0"}, int'(busy), int'(v.exp_beats > 0));
            if (cyc == 1 && v.exp_beats > 0) begin
                chk({tag, ":addr_first"}, int'(ram_addr), int'(v.addr));
                prev_ra = ram_addr; naddr = 1;
            end else if (cyc > 1 && naddr > 0 && naddr < 8 && naddr < v.exp_beats && ram_addr != prev_ra) begin
                exp_a = (int'(v.addr) + naddr) % DEPTH;
                chk({tag, ":addr_seq"}, int'(ram_addr), exp_a);
                prev_ra = ram_addr; naddr++;
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                chk({tag, ":stall_valid"}, int'(m_valid), 1);
                chk({tag, ":stall_data"}, int'(m_data), int'(pd));
                chk({tag, ":stall_last"}, int'(m_last), int'(pl));
            end
            if (m_valid && m_ready) begin
                if (beats < v.exp_beats) begin
                    chk({tag, ":data"}, int'(m_data), int'(ramf(AW'((int'(v.addr) + beats) % DEPTH))));
                    chk({tag, ":last"}, int'(m_last), int'(beats == v.exp_beats - 1));
                end else begin
                    chk({tag, ":extra_beat"}, beats + 1, v.exp_beats);
                end
                beats++;
                if (m_last) last_cyc = cyc;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({tag, ":busy_at_done"}, int'(busy), 0);
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            @(posedge clk); #1;
            cyc++;
            m_ready = rdy(v.mode, cyc);
            if (v.poke && cyc == 5) begin
                start = 1'b1; start_addr = AW'(7); length = (AW+1)'(3);
            end else begin
                start = 1'b0; start_addr = '0; length = '0;
            end
        end
        chk({tag, ":beats"}, beats, v.exp_beats);
        chk({tag, ":done_pulses"}, dones, 1);
        if (v.exp_beats > 0) begin
            chk({tag, ":first_valid_cyc"}, first_v, LAT + 2);
            chk({tag, ":done_after_last"}, done_cyc, last_cyc + 1);
            chk({tag, ":addr_count"}, naddr, (v.exp_beats < 8) ? v.exp_beats : 8);
        end else begin
            chk({tag, ":done_cyc"}, done_cyc, 0);
            chk({tag, ":no_valid"}, first_v, -1);
        end
    endtask

    initial begin
        int got, guard, seen;
        vecs[0] = '{13'd100,  14'd5,    0, 5,    1'b0};
        vecs[1] = '{13'd8190, 14'd4,    0, 4,    1'b0};
        vecs[2] = '{13'd50,   14'd16,   1, 16,   1'b0};
        vecs[3] = '{13'd0,    14'd0,    0, 0,    1'b0};
        vecs[4] = '{13'd8000, 14'd9000, 0, 8192, 1'b0};
        vecs[5] = '{13'd1234, 14'd1,    2, 1,    1'b0};
        vecs[6] = '{13'd4000, 14'd30,   2, 30,   1'b0};
        vecs[7] = '{13'd200,  14'd10,   1, 10,   1'b1};
        vecs[8] = '{13'd8191, 14'd8192, 2, 8192, 1'b0};

        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 outputs_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // abort in the middle of a long request
        @(posedge clk); #1;
        m_ready = 1'b1; start = 1'b1; start_addr = AW'(300); length = (AW+1)'(64);
        @(posedge clk); #1;
        start = 1'b0;
        got = 0; guard = 0;
        do begin
            @(negedge clk);
            if (m_valid && m_ready) got++;
            guard++;
            if (got < 20) @(posedge clk);
        end while (got < 20 && guard < 300);
        chk("abort:reach20", got, 20);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort:m_valid", int'(m_valid), 0);
        chk("abort:busy", int'(busy), 0);
        seen = 0;
        repeat (6) begin
            if (done || m_valid || busy) seen++;
            @(negedge clk);
        end
        chk("abort:quiet", seen, 0);
        run_vec('{13'd0, 14'd2, 0, 2, 1'b0}, "post_abort");

        // start and abort together: start must be dropped
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; start_addr = AW'(5); length = (AW+1)'(3);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || m_valid || busy) seen++;
        end
        chk("start_abort:quiet", seen, 0);

        // asynchronous reset in the middle of a request
        @(posedge clk); #1;
        start = 1'b1; start_addr = AW'(500); length = (AW+1)'(40);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 outputs_zero("midrun_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || m_valid || busy) seen++;
        end
        chk("midrun_reset:quiet", seen, 0);
        run_vec('{13'd777, 14'd6, 0, 6, 1'b0}, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_frame_reader.md
Name: dpram_frame_reader

Overview:
Read-side engine for the 8192-deep capture DPRAM. It drives the RAM read-port address and turns the fixed-latency read data into a valid/ready sample stream with a last-beat marker. Reads are circular, starting at a programmable address, for the downstream display/FFT path. A small skid FIFO absorbs the RAM latency, so backpressure never loses or duplicates a sample.

Parameters:
ADDR_WIDTH, 13, RAM address width; buffer depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 10, sample width; matches RAM port width
FIFO_DEPTH, 4, skid FIFO entries; must be at least RAM read latency + 2

Ports:
clk  in  1  single clock, shared with RAM read port
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored while busy=1
start_addr  in  ADDR_WIDTH  first RAM address to read
length  in  ADDR_WIDTH+1  beats to read; 0 means none; values above DEPTH are clamped to DEPTH
abort  in  1  synchronous flush back to IDLE
ram_addr  out  ADDR_WIDTH  RAM read address (registered)
ram_rd_data  in  DATA_WIDTH  RAM read data, valid LAT cycles after ram_addr
m_data  out  DATA_WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  marks the final beat of a request
busy  out  1  request in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, async): state IDLE, FIFO empty. ram_addr=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0. In-flight reads are discarded.
- LAT = 1 by default; RAM has no output register.
- States:
  - IDLE. On start with length>0: latch start_addr and the clamped length, go to RUN, busy=1 next cycle. On start with length=0: done=1 next cycle, stay IDLE, emit no beats.
  - RUN. Each cycle where issued_remaining>0 and (fifo_count + inflight) < FIFO_DEPTH: drive ram_addr with the next address, decrement issued_remaining, advance the address. After the final issue, go to DRAIN.
  - DRAIN. Wait until all in-flight reads have landed and the last beat is accepted, then go to IDLE.
- Address arithmetic: addr_next = (addr + 1) mod DEPTH. Wrap-around is silent, so start_addr=8190 with length=4 reads 8190, 8191, 0, 1.
- In-flight tracking: a LAT-stage valid shift register, one bit per issued address. Data is pushed into the FIFO when the shift-register output bit is 1. A tag bit marking the final issued address travels alongside and becomes m_last.
- Stream handshake: a beat transfers when m_valid && m_ready. m_data and m_last are stable while m_valid=1 && m_ready=0. m_valid is FIFO non-empty, driven from a register.
- Latency: with start accepted at edge 0, ram_addr is valid in cycle 1 and m_valid rises in cycle 3 (m_ready=1). Throughput is 1 beat/clk with m_ready held high.
- Completion: on the edge after the m_last beat is accepted, busy falls and done=1 for exactly one cycle. ram_addr holds its last value while IDLE.
- Backpressure: issuing stalls via the credit rule. The FIFO never overflows and every address is read exactly once.
- abort (any state): takes priority over start and over the handshake. On the next edge: FIFO flushed, in-flight reads dropped, m_valid=0, busy=0, state IDLE, no done pulse. If start and abort occur in the same cycle, start is ignored.
- start while busy=1: ignored with no side effects.

Optional Feature:
Macro DPRAM_READER_OREG_EN.
- Defined: LAT=2, matching a RAM with the output register enabled. The in-flight shift register has 2 stages, first m_valid arrives in cycle 4, and FIFO_DEPTH is checked at elaboration to be at least 4.
- Undefined: LAT=1 as specified above.

Decomposition:
- Shared package dpram_reader_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the localparam LAT, selected by the macro;
  - the DEPTH derivation function.
- One sub-module, dpram_reader_skid_fifo: synchronous FIFO of FIFO_DEPTH × (DATA_WIDTH+1), with push/pop/count/flush, async active-low reset, and registered outputs.
- The top level holds the FSM, address counter, credit logic and in-flight shift register.

Test Plan:
- Simple read: RAM[i]=i; start_addr=100, length=5, m_ready=1 -> m_data 100..104 on consecutive cycles from cycle 3; m_last on 104; done one cycle later.
- Wrap-around: start_addr=8190, length=4 -> ram_addr sequence 8190, 8191, 0, 1; data in that order; m_last on addr 1.
- Backpressure: length=16 with m_ready toggling 1,0,0,1,... -> all 16 beats delivered in order, none lost or duplicated; ram_addr issues never exceed FIFO credit; m_data stable while stalled.
- Zero and over-length: length=0 -> done pulse, no m_valid; length=9000 -> exactly 8192 beats, then done.
- Abort mid-run: length=64, abort at beat 20 -> m_valid=0 and busy=0 next cycle, no done; a following start (addr 0, length 2) produces only the new 2 beats.
- Reset and ignored start: rst_n low mid-RUN -> all outputs 0 immediately; a start pulse while busy is ignored and the original sequence completes unchanged.
